// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB slave register bank model.
package apb_pkg;

   localparam int WAIT_CNT_W = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   // Byte address to word index shift for the supported bus widths.
   function automatic int word_shift(input int data_width);
      case (data_width)
         8:       return 0;
         16:      return 1;
         default: return 2;
      endcase
   endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state down-counter: loads on the setup strobe, counts down during access.
module apb_wait_counter
   import apb_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_load,
   input  logic                  i_dec,
   input  logic [WAIT_CNT_W-1:0] i_load_val,
   output logic [WAIT_CNT_W-1:0] o_cnt,
   output logic                  o_zero
);

   logic [WAIT_CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - WAIT_CNT_W'(1);
      end
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/apb_slave_bank.sv
// APB slave with NUM_SLAVES word-addressed register banks and programmable wait states.
// Define APB_SLVERR_EN to report out-of-range or multi-hot selects on Pslverr.
module apb_slave_bank
   import apb_pkg::*;
#(
   parameter int NUM_SLAVES  = 3,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic                  Hclk,
   input  logic                  Hreset,
   input  logic [NUM_SLAVES-1:0] Psel,
   input  logic                  Penable,
   input  logic                  Pwrite,
   input  logic [ADDR_WIDTH-1:0] Paddr,
   input  logic [DATA_WIDTH-1:0] Pwdata,
   output logic [DATA_WIDTH-1:0] Prdata,
   output logic                  Pready,
   output logic                  Pslverr
);

   localparam int SHIFT  = word_shift(DATA_WIDTH);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int BANK_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   state_t                  r_state;
   state_t                  w_next;
   logic [DATA_WIDTH-1:0]   r_mem [NUM_SLAVES][DEPTH];
   logic [DATA_WIDTH-1:0]   r_prdata;
   logic [ADDR_WIDTH-1:0]   w_word;
   logic [IDX_W-1:0]        w_idx;
   logic [BANK_W-1:0]       w_bank;
   logic [WAIT_CNT_W-1:0]   w_cnt;
   logic                    w_cnt_zero;
   logic                    w_sel_any;
   logic                    w_multi;
   logic                    w_in_range;
   logic                    w_legal;
   logic                    w_setup;

   assign w_sel_any  = |Psel;
   assign w_multi    = |(Psel & (Psel - NUM_SLAVES'(1)));
   assign w_word     = Paddr >> SHIFT;
   assign w_in_range = (w_word < ADDR_WIDTH'(DEPTH));
   assign w_idx      = w_word[IDX_W-1:0];
   assign w_setup    = (r_state == IDLE) && w_sel_any && !Penable;

   // Lowest set bit of Psel picks the bank.
   always_comb begin
      w_bank = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (Psel[i]) w_bank = BANK_W'(i);
      end
   end

`ifdef APB_SLVERR_EN
   assign w_legal = w_in_range && !w_multi;
   assign Pslverr = Pready && !w_legal;
`else
   assign w_legal = w_in_range;
   assign Pslverr = 1'b0;
`endif

   apb_wait_counter u_wait_counter (
      .i_clk      (Hclk),
      .i_rst      (Hreset),
      .i_load     (w_setup),
      .i_dec      (r_state == ACCESS),
      .i_load_val (WAIT_CNT_W'(WAIT_STATES)),
      .o_cnt      (w_cnt),
      .o_zero     (w_cnt_zero)
   );

   assign Pready = (r_state == ACCESS) && w_sel_any && Penable && w_cnt_zero;

   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Dropping Psel in ACCESS aborts the transfer without a write.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_setup) w_next = ACCESS;
         ACCESS:  if (!w_sel_any || Pready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         for (int i = 0; i < NUM_SLAVES; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
               r_mem[i][j] <= '0;
            end
         end
      end else if (Pready && Pwrite && w_legal) begin
         r_mem[w_bank][w_idx] <= Pwdata;
      end
   end

   // Read data is captured at setup so it is stable for the whole access phase.
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         r_prdata <= '0;
      end else if (w_setup && !Pwrite) begin
         r_prdata <= w_legal ? r_mem[w_bank][w_idx] : '0;
      end
   end

   assign Prdata = r_prdata;

   logic w_unused;
   assign w_unused = ^w_cnt;

endmodule

// File: tb/tb_apb_slave_bank.sv
// Scoreboard bench for apb_slave_bank: three instances with 0, 2 and 3 wait states.
module tb_apb_slave_bank;

   localparam int NS    = 3;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 16;
   localparam int ND    = 3;

`ifdef APB_SLVERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          hclk = 1'b0;
   logic          hreset;
   logic [NS-1:0] psel    [ND];
   logic          penable [ND];
   logic          pwrite  [ND];
   logic [AW-1:0] paddr   [ND];
   logic [DW-1:0] pwdata  [ND];
   logic [DW-1:0] prdata  [ND];
   logic          pready  [ND];
   logic          pslverr [ND];

   always #5 hclk = ~hclk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      apb_slave_bank #(
         .NUM_SLAVES  (NS),
         .DATA_WIDTH  (DW),
         .ADDR_WIDTH  (AW),
         .DEPTH       (DEPTH),
         .WAIT_STATES (g == 0 ? 0 : g + 1)
      ) u_dut (
         .Hclk    (hclk),
         .Hreset  (hreset),
         .Psel    (psel[g]),
         .Penable (penable[g]),
         .Pwrite  (pwrite[g]),
         .Paddr   (paddr[g]),
         .Pwdata  (pwdata[g]),
         .Prdata  (prdata[g]),
         .Pready  (pready[g]),
         .Pslverr (pslverr[g])
      );
   end

   typedef struct {
      logic [DW-1:0] rdata;
      logic          slverr;
      int            waits;
   } exp_t;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW-1:0] mem    [ND][NS][DEPTH];
   logic [DW-1:0] exp_rd [ND];
   exp_t          sb[$];

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : d + 1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < ND; d++) begin
         exp_rd[d] = '0;
         for (int b = 0; b < NS; b++)
            for (int w = 0; w < DEPTH; w++) mem[d][b][w] = '0;
      end
      sb.delete();
   endtask

   task automatic bus_idle(input int d);
      psel[d]    = '0;
      penable[d] = 1'b0;
      pwrite[d]  = 1'b0;
      paddr[d]   = '0;
      pwdata[d]  = '0;
   endtask

   // Full transfer; called at posedge+1, returns at posedge+1 after completion.
   task automatic xfer(input int d, input logic [NS-1:0] sel, input logic wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd, input string name);
      int   b;
      int   idx;
      bit   inr;
      bit   multi;
      bit   legal;
      bit   done;
      exp_t e;
      exp_t got;
      b = 0;
      for (int i = NS - 1; i >= 0; i--) if (sel[i]) b = i;
      inr   = (addr >> 2) < AW'(DEPTH);
      multi = $countones(sel) > 1;
      legal = inr && !(ERR_EN && multi);
      idx   = int'(addr >> 2) & (DEPTH - 1);
      if (!wr) exp_rd[d] = legal ? mem[d][b][idx] : '0;
      e.rdata  = exp_rd[d];
      e.slverr = ERR_EN && !legal;
      e.waits  = ws_of(d);
      sb.push_back(e);
      if (wr && legal) mem[d][b][idx] = wd;

      psel[d]    = sel;
      penable[d] = 1'b0;
      pwrite[d]  = wr;
      paddr[d]   = addr;
      pwdata[d]  = wd;
      @(negedge hclk);
      n_cmp++;
      if (pready[d] !== 1'b0) begin
         n_err++;
         $display("FAIL %s setup_pready: got %b want 0", name, pready[d]);
      end
      @(posedge hclk); #1;
      penable[d] = 1'b1;
      done = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         @(negedge hclk);
         n_cmp++;
         if (prdata[d] !== exp_rd[d]) begin
            n_err++;
            $display("FAIL %s prdata_c%0d: got %h want %h", name, cyc, prdata[d], exp_rd[d]);
         end
         if (pready[d] === 1'b1) begin
            done = 1'b1;
            got  = sb.pop_front();
            n_cmp++;
            if (cyc != got.waits) begin
               n_err++;
               $display("FAIL %s wait_cycles: got %0d want %0d", name, cyc, got.waits);
            end
            n_cmp++;
            if (pslverr[d] !== got.slverr) begin
               n_err++;
               $display("FAIL %s pslverr: got %b want %b", name, pslverr[d], got.slverr);
            end
            n_cmp++;
            if (prdata[d] !== got.rdata) begin
               n_err++;
               $display("FAIL %s rdata: got %h want %h", name, prdata[d], got.rdata);
            end
         end else begin
            n_cmp++;
            if (pslverr[d] !== 1'b0) begin
               n_err++;
               $display("FAIL %s pslverr_no_ready: got %b want 0", name, pslverr[d]);
            end
         end
         @(posedge hclk); #1;
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s timeout: got no Pready want Pready within 40 cycles", name);
         if (sb.size() > 0) void'(sb.pop_front());
      end
   endtask

   task automatic test_reset();
      hreset = 1'b1;
      for (int d = 0; d < ND; d++) bus_idle(d);
      model_reset();
      repeat (3) @(posedge hclk);
      #1;
      hreset = 1'b0;
      @(negedge hclk);
      for (int d = 0; d < ND; d++) begin
         n_cmp++;
         if (pready[d] !== 1'b0) begin
            n_err++; $display("FAIL reset_pready%0d: got %b want 0", d, pready[d]);
         end
         n_cmp++;
         if (pslverr[d] !== 1'b0) begin
            n_err++; $display("FAIL reset_pslverr%0d: got %b want 0", d, pslverr[d]);
         end
         n_cmp++;
         if (prdata[d] !== '0) begin
            n_err++; $display("FAIL reset_prdata%0d: got %h want 0", d, prdata[d]);
         end
      end
      @(posedge hclk); #1;
   endtask

   task automatic test_write_read();
      xfer(0, 3'b010, 1'b1, 32'h8, 32'hDEAD_BEEF, "wr_b1");
      xfer(0, 3'b010, 1'b0, 32'h8, '0, "rd_b1");
      xfer(0, 3'b001, 1'b0, 32'h8, '0, "rd_b0_other_bank");
      xfer(0, 3'b010, 1'b0, 32'hB, '0, "rd_b1_byte_offset");
      xfer(0, 3'b100, 1'b1, 32'h3C, 32'hCAFE_F00D, "wr_last_word");
      xfer(0, 3'b100, 1'b0, 32'h3C, '0, "rd_last_word");
      bus_idle(0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++)
         xfer(0, 3'b100, 1'b1, AW'(i * 4), DW'(32'h1000_0000 + i * 32'h0101), "b2b_wr");
      for (int i = 3; i >= 0; i--)
         xfer(0, 3'b100, 1'b0, AW'(i * 4), '0, "b2b_rd");
      bus_idle(0);
   endtask

   task automatic test_wait_states();
      xfer(2, 3'b001, 1'b0, 32'h0, '0, "ws3_rd_reset_val");
      xfer(2, 3'b001, 1'b1, 32'h4, 32'h7777_0001, "ws3_wr");
      xfer(2, 3'b001, 1'b0, 32'h4, '0, "ws3_rd");
      xfer(1, 3'b010, 1'b1, 32'h20, 32'h5555_AAAA, "ws2_wr");
      xfer(1, 3'b010, 1'b0, 32'h20, '0, "ws2_rd");
      bus_idle(1);
      bus_idle(2);
   endtask

   task automatic test_out_of_range();
      xfer(0, 3'b100, 1'b1, 32'h0, 32'h0BAD_0001, "oor_prep");
      xfer(0, 3'b100, 1'b0, 32'h40, '0, "oor_rd");
      xfer(0, 3'b100, 1'b1, 32'h40, 32'hFFFF_FFFF, "oor_wr");
      xfer(0, 3'b100, 1'b1, 32'h8000_0000, 32'hEEEE_EEEE, "oor_wr_hibit");
      xfer(0, 3'b100, 1'b0, 32'h0, '0, "oor_no_alias");
      xfer(2, 3'b100, 1'b0, 32'h44, '0, "oor_rd_ws3");
      bus_idle(0);
      bus_idle(2);
   endtask

   task automatic test_multi_hot();
      xfer(0, 3'b011, 1'b1, 32'h4, 32'h1234, "mh_wr");
      xfer(0, 3'b001, 1'b0, 32'h4, '0, "mh_rd_b0");
      xfer(0, 3'b010, 1'b0, 32'h4, '0, "mh_rd_b1");
      xfer(0, 3'b011, 1'b0, 32'h4, '0, "mh_rd_multi");
      bus_idle(0);
   endtask

   task automatic test_abort();
      xfer(1, 3'b001, 1'b1, 32'hC, 32'h1111_1111, "abort_prep");
      psel[1]    = 3'b001;
      penable[1] = 1'b0;
      pwrite[1]  = 1'b1;
      paddr[1]   = 32'hC;
      pwdata[1]  = 32'h2222_2222;
      @(posedge hclk); #1;
      penable[1] = 1'b1;
      @(negedge hclk);
      n_cmp++;
      if (pready[1] !== 1'b0) begin
         n_err++; $display("FAIL abort_early_ready: got %b want 0", pready[1]);
      end
      @(posedge hclk); #1;
      psel[1]    = '0;
      penable[1] = 1'b0;
      @(posedge hclk); #1;
      // Penable without a setup phase must be ignored once back in IDLE.
      psel[1]    = 3'b001;
      penable[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge hclk);
         n_cmp++;
         if (pready[1] !== 1'b0) begin
            n_err++; $display("FAIL abort_idle_enable_c%0d: got pready %b want 0", i, pready[1]);
         end
         @(posedge hclk); #1;
      end
      bus_idle(1);
      @(posedge hclk); #1;
      xfer(1, 3'b001, 1'b0, 32'hC, '0, "abort_rd_old");
      bus_idle(1);
   endtask

   task automatic test_reset_mid();
      xfer(2, 3'b010, 1'b1, 32'h10, 32'hA5A5_A5A5, "rst_wr");
      xfer(2, 3'b010, 1'b0, 32'h10, '0, "rst_rd");
      psel[2]    = 3'b010;
      penable[2] = 1'b0;
      pwrite[2]  = 1'b0;
      paddr[2]   = 32'h10;
      @(posedge hclk); #1;
      penable[2] = 1'b1;
      #1;
      hreset = 1'b1;
      #1;
      n_cmp++;
      if (pready[2] !== 1'b0) begin
         n_err++; $display("FAIL rstmid_pready: got %b want 0", pready[2]);
      end
      n_cmp++;
      if (prdata[2] !== '0) begin
         n_err++; $display("FAIL rstmid_prdata: got %h want 0", prdata[2]);
      end
      n_cmp++;
      if (pslverr[2] !== 1'b0) begin
         n_err++; $display("FAIL rstmid_pslverr: got %b want 0", pslverr[2]);
      end
      for (int d = 0; d < ND; d++) bus_idle(d);
      model_reset();
      @(posedge hclk); #1;
      hreset = 1'b0;
      @(posedge hclk); #1;
      xfer(2, 3'b010, 1'b0, 32'h10, '0, "rstmid_rd_after");
      xfer(0, 3'b010, 1'b0, 32'h8, '0, "rstmid_rd_other_dut");
      bus_idle(0);
      bus_idle(2);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_wait_states();
      test_out_of_range();
      test_multi_hot();
      test_abort();
      test_reset_mid();
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++; $display("FAIL scoreboard_empty: got %0d left want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/apb_slave_bank.md
# apb_slave_bank

Parametrised APB slave model for the AHB-to-APB bridge testbench and system top. It replaces the fixed random-data slave with NUM_SLAVES independent word-addressed register banks. Each bank returns the data actually written, inserts programmable wait states through Pready, and can flag illegal accesses on Pslverr. It sits on the bridge's APB master side and terminates Psel, Penable, Pwrite, Paddr and Pwdata.

## Interface
- NUM_SLAVES, 3: number of banks; width of Psel.
- DATA_WIDTH, 32: Pwdata/Prdata width; must be 8, 16 or 32.
- ADDR_WIDTH, 32: Paddr width.
- DEPTH, 16: words per bank; power of two, ≥2.
- WAIT_STATES, 0: access-phase cycles with Pready low before completion; 0..15.
- Hclk  input  1  single clock; all state on rising edge.
- Hreset  input  1  asynchronous, active-high reset.
- Psel  input  NUM_SLAVES  one-hot bank select.
- Penable  input  1  access phase.
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  ADDR_WIDTH  byte address.
- Pwdata  input  DATA_WIDTH  write data.
- Prdata  output  DATA_WIDTH  registered read data.
- Pready  output  1  transfer completion.
- Pslverr  output  1  error response, valid only with Pready.

## Operation
- Word index: Paddr >> log2(DATA_WIDTH/8). In range when index < DEPTH and all higher Paddr bits are 0.
- Selected bank: lowest set bit of Psel. Multi-hot Psel is an illegal select.
- FSM has two states, IDLE and ACCESS, plus a 4-bit wait counter `cnt`.
  - IDLE -> ACCESS when |Psel && !Penable (setup phase). On that edge, `cnt` loads WAIT_STATES.
  - In ACCESS, `cnt` decrements each cycle while non-zero.
  - ACCESS -> IDLE on completion, or when Psel drops to 0 (abort).
  - Penable high while in IDLE is ignored: no Pready, no write, FSM stays in IDLE.
- Pready = (state==ACCESS) && |Psel && Penable && cnt==0. It is combinational from state and inputs.
- Write: the bank word updates on the completion edge only. Out-of-range or illegal accesses do not write.
- Read: Prdata loads the selected word at the setup edge, or 0 if out of range. It holds until the next read setup. Writes never change Prdata.
- Abort before completion: no write occurs. Prdata keeps its loaded value.
- Back-to-back transfers: a setup phase in the cycle after completion starts a new transfer normally.
- Reset, including mid-transfer: state=IDLE, cnt=0, Prdata=0, Pready=0, Pslverr=0, all bank words=0.

## Timing
- Setup at cycle T. With WAIT_STATES=N, Pready is high in cycle T+1+N.
- Minimum transfer is 2 cycles (N=0).
- Prdata is stable from T+1 through completion.
- Pslverr is never high unless Pready is high in the same cycle.

## Configuration
- APB_SLVERR_EN defined:
  - Pslverr = Pready && (index out of range || Psel multi-hot).
  - The erroring transfer writes nothing and reads return 0.
- APB_SLVERR_EN undefined:
  - Pslverr is tied to 0.
  - Out-of-range reads return 0 and out-of-range writes are dropped silently.
  - Multi-hot Psel uses the lowest set bit as a normal access.

## Structure
- Package apb_pkg holds:
  - the state typedef (IDLE, ACCESS);
  - the function computing the word-index shift from DATA_WIDTH;
  - the constant WAIT_CNT_W=4.
- One natural sub-module, apb_wait_counter: load/decrement/zero-flag counter driven by setup and access strobes.
- Banks are a 2-D register array in the top module, not separate instances.

## Test plan
- Reset, then write 32'hDEAD_BEEF to bank 1 at Paddr 0x8, then read it back -> Pready high on the 2nd cycle of each transfer, Prdata=32'hDEAD_BEEF, Pslverr=0.
- WAIT_STATES=3, read bank 0 at Paddr 0x0 -> Pready low for 3 access cycles and high on the 4th; Prdata=0 after reset.
- Read bank 2 at Paddr 0x40 with DEPTH=16 -> Prdata=0. Pslverr=1 with APB_SLVERR_EN, 0 without; no bank word changes.
- Psel=3'b011 write of 32'h1234 to Paddr 0x4 -> with APB_SLVERR_EN, Pslverr=1 and no write; without it, bank 0 word 1 = 32'h1234 and bank 1 is unchanged.
- WAIT_STATES=2 write, Psel dropped after 1 access cycle -> no completion, target word keeps its old value, FSM returns to IDLE.
- Hreset asserted mid-access after writing 32'hA5A5A5A5 -> Pready/Prdata/Pslverr 0 immediately; a following read of the same address returns 0.
